// File: rtl/bus_arbiter_if.sv
// Request/response bundle shared by the bus masters, the round-robin
// arbiter and the single slave bus it drives.
interface bus_arbiter_if #(
   parameter int N_MASTERS = 2,
   parameter int AW        = 32,
   parameter int DW        = 32
);
   localparam int BW = DW / 8;
   localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

   logic [N_MASTERS-1:0]    i_m_bus_en;
   logic [N_MASTERS-1:0]    i_m_wr_en;
   logic [N_MASTERS*AW-1:0] i_m_addr;
   logic [N_MASTERS*DW-1:0] i_m_wr_data;
   logic [N_MASTERS*BW-1:0] i_m_byte_en;
   logic [N_MASTERS*DW-1:0] o_m_rd_data;
   logic [N_MASTERS-1:0]    o_m_ack;
   logic [N_MASTERS-1:0]    o_m_err;

   logic                    o_s_bus_en;
   logic                    o_s_wr_en;
   logic [AW-1:0]           o_s_addr;
   logic [DW-1:0]           o_s_wr_data;
   logic [BW-1:0]           o_s_byte_en;
   logic [DW-1:0]           i_s_rd_data;
   logic                    i_s_ack;

   logic [GW-1:0]           o_grant;

   // Arbiter view: takes master requests, drives the slave bus.
   modport master (
      input  i_m_bus_en, i_m_wr_en, i_m_addr,
      input  i_m_wr_data, i_m_byte_en,
      output o_m_rd_data, o_m_ack, o_m_err,
      output o_s_bus_en, o_s_wr_en, o_s_addr,
      output o_s_wr_data, o_s_byte_en,
      input  i_s_rd_data, i_s_ack,
      output o_grant
   );

   // Environment view: requesters plus the slave.
   modport slave (
      output i_m_bus_en, i_m_wr_en, i_m_addr,
      output i_m_wr_data, i_m_byte_en,
      input  o_m_rd_data, o_m_ack, o_m_err,
      input  o_s_bus_en, o_s_wr_en, o_s_addr,
      input  o_s_wr_data, o_s_byte_en,
      output i_s_rd_data, i_s_ack,
      input  o_grant
   );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one slave bus among N_MASTERS requesters.
// Define ARB_TIMEOUT_EN to build the BUSY-state watchdog.
module bus_arbiter #(
   parameter int N_MASTERS      = 2,
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic          i_clk,
   input  logic          i_rst,
   bus_arbiter_if.master bus
);
   localparam int BW = DW / 8;
   localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [GW-1:0] ptr_q, ptr_d;
   logic [GW-1:0] winner, idx, grant_nxt;
   logic          any_req;
   logic          busy, own, ack, tmo, term;

   assign busy = (state_q == S_BUSY);
   assign own  = busy && bus.i_m_bus_en[grant_q];
   assign ack  = own && bus.i_s_ack;
   assign term = own && !bus.i_s_ack && tmo;

   assign grant_nxt = (grant_q == GW'(N_MASTERS - 1)) ?
                      '0 : grant_q + 1'b1;

   // First requester at or after ptr, searching upward with wrap.
   always_comb begin
      winner  = ptr_q;
      idx     = '0;
      any_req = 1'b0;
      for (int i = 0; i < N_MASTERS; i++) begin
         idx = GW'((int'(ptr_q) + i) % N_MASTERS);
         if (!any_req && bus.i_m_bus_en[idx]) begin
            any_req = 1'b1;
            winner  = idx;
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;

   assign tmo = busy &&
                (cnt_q == 16'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (!busy) begin
         cnt_d = '0;
      end else if (!bus.i_s_ack) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               state_d = S_BUSY;
               grant_d = winner;
            end
         end
         S_BUSY: begin
            // Completion, abandon and timeout all release the bus.
            if (!own || ack || term) begin
               state_d = S_IDLE;
               ptr_d   = grant_nxt;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.o_s_bus_en  = own && !term;
      bus.o_s_wr_en   = 1'b0;
      bus.o_s_addr    = '0;
      bus.o_s_wr_data = '0;
      bus.o_s_byte_en = '0;
      bus.o_m_rd_data = '0;
      bus.o_m_ack     = '0;
      bus.o_m_err     = '0;
      bus.o_grant     = '0;
      if (busy) begin
         bus.o_s_wr_en   = bus.i_m_wr_en[grant_q];
         bus.o_s_addr    = bus.i_m_addr[grant_q*AW +: AW];
         bus.o_s_wr_data = bus.i_m_wr_data[grant_q*DW +: DW];
         bus.o_s_byte_en = bus.i_m_byte_en[grant_q*BW +: BW];
         bus.o_grant     = grant_q;
         if (!term) begin
            bus.o_m_rd_data[grant_q*DW +: DW] = bus.i_s_rd_data;
         end
         bus.o_m_ack[grant_q] = ack || term;
         bus.o_m_err[grant_q] = term;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end
endmodule
